// File: rtl/copy.sv
// rtl/copy.sv - one-to-two token duplicator with a private holding register per output
// Optional accepted-token counter port tok_cnt is enabled by defining COPY_CNT_EN.
module copy #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] L_data,
    input  logic             L_valid,
    output logic             L_ready,
    output logic [WIDTH-1:0] R0_data,
    output logic             R0_valid,
    input  logic             R0_ready,
    output logic [WIDTH-1:0] R1_data,
    output logic             R1_valid,
    input  logic             R1_ready
`ifdef COPY_CNT_EN
    ,
    output logic [15:0]      tok_cnt
`endif
);

    logic l_xfer;

    // Accept only when both holding registers are empty or draining this edge,
    // so a new token never overwrites an undelivered copy.
    assign L_ready = !rst && (!R0_valid || R0_ready) && (!R1_valid || R1_ready);
    assign l_xfer  = L_valid && L_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            R0_valid <= 1'b0;
            R1_valid <= 1'b0;
            R0_data  <= '0;
            R1_data  <= '0;
        end else if (l_xfer) begin
            R0_valid <= 1'b1;
            R1_valid <= 1'b1;
            R0_data  <= L_data;
            R1_data  <= L_data;
        end else begin
            if (R0_ready) R0_valid <= 1'b0;
            if (R1_ready) R1_valid <= 1'b0;
        end
    end

`ifdef COPY_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tok_cnt <= 16'd0;
        end else if (l_xfer) begin
            tok_cnt <= tok_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_copy.sv
// tb/tb_copy.sv - directed and randomized checks of the copy duplicator with a token scoreboard
module tb_copy;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] L_data;
    logic       L_valid;
    logic       L_ready;
    logic [7:0] R0_data;
    logic       R0_valid;
    logic       R0_ready;
    logic [7:0] R1_data;
    logic       R1_valid;
    logic       R1_ready;
`ifdef COPY_CNT_EN
    logic [15:0] tok_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    copy #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .L_data   (L_data),
        .L_valid  (L_valid),
        .L_ready  (L_ready),
        .R0_data  (R0_data),
        .R0_valid (R0_valid),
        .R0_ready (R0_ready),
        .R1_data  (R1_data),
        .R1_valid (R1_valid),
        .R1_ready (R1_ready)
`ifdef COPY_CNT_EN
        ,
        .tok_cnt  (tok_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted L token must leave each output exactly once, in order.
    always @(negedge clk) begin
        if (rst) begin
            q0.delete();
            q1.delete();
        end else begin
            if (R0_valid && R0_ready) begin
                if (q0.size() == 0) check("r0_extra", q0.size(), 1);
                else begin
                    check("r0_data", R0_data, q0[0]);
                    void'(q0.pop_front());
                end
            end
            if (R1_valid && R1_ready) begin
                if (q1.size() == 0) check("r1_extra", q1.size(), 1);
                else begin
                    check("r1_data", R1_data, q1[0]);
                    void'(q1.pop_front());
                end
            end
            if (L_valid && L_ready) begin
                q0.push_back(L_data);
                q1.push_back(L_data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int accepted;
        int cycles;
        logic acc;

        rst = 1'b1; L_valid = 1'b1; L_data = 8'hFF; R0_ready = 1'b1; R1_ready = 1'b1;

        // Reset with L_valid high
        repeat (2) begin
            @(negedge clk);
            check("rst_lrdy", L_ready, 0);
            check("rst_r0v", R0_valid, 0);
            check("rst_r1v", R1_valid, 0);
            check("rst_r0d", R0_data, 0);
            check("rst_r1d", R1_data, 0);
        end
        L_valid = 1'b0;
        step();

        // Single token, accepted on the first edge with rst low
        rst = 1'b0; L_valid = 1'b1; L_data = 8'hA5;
        @(negedge clk);
        check("single_lrdy", L_ready, 1);
        step();
        L_valid = 1'b0;
        @(negedge clk);
        check("single_r0v", R0_valid, 1);
        check("single_r0d", R0_data, 8'hA5);
        check("single_r1v", R1_valid, 1);
        check("single_r1d", R1_data, 8'hA5);
        step();
        @(negedge clk);
        check("single_r0_empty", R0_valid, 0);
        check("single_r1_empty", R1_valid, 0);

        // Back-to-back streaming 01..10
        step();
        L_valid = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            L_data = 8'(i);
            @(negedge clk);
            check("stream_lrdy", L_ready, 1);
            if (i > 1) begin
                check("stream_r0d", R0_data, 8'(i - 1));
                check("stream_r1d", R1_data, 8'(i - 1));
            end
            step();
        end
        L_valid = 1'b0;
        @(negedge clk);
        check("stream_last_r0", R0_data, 8'h10);
        check("stream_last_r1", R1_data, 8'h10);
        step();

        // Skewed consumers: R1 stalls holding 3C
        L_valid = 1'b1; L_data = 8'h3C;
        step();
        L_data = 8'h3D; R1_ready = 1'b0;
        @(negedge clk);
        check("skew_lrdy0", L_ready, 0);
        check("skew_r1d0", R1_data, 8'h3C);
        step();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("skew_r0v", R0_valid, 0);
            check("skew_r1v", R1_valid, 1);
            check("skew_r1d", R1_data, 8'h3C);
            check("skew_lrdy", L_ready, 0);
            step();
        end
        R1_ready = 1'b1;
        @(negedge clk);
        check("skew_lrdy_release", L_ready, 1);
        step();
        L_valid = 1'b0;
        @(negedge clk);
        check("skew_next_r0", R0_data, 8'h3D);
        check("skew_next_r1", R1_data, 8'h3D);
        step();
        @(negedge clk);
        check("skew_drained", R1_valid, 0);

        // Mid-run reset with both holds full
        step();
        R0_ready = 1'b0; R1_ready = 1'b0; L_valid = 1'b1; L_data = 8'h55;
        step();
        L_valid = 1'b0;
        @(negedge clk);
        check("mid_full_r0", R0_valid, 1);
        check("mid_full_r1", R1_valid, 1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("mid_r0v", R0_valid, 0);
        check("mid_r1v", R1_valid, 0);
        R0_ready = 1'b1; R1_ready = 1'b1;
        L_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            L_data = 8'h70 + 8'(i);
            step();
        end
        L_valid = 1'b0;
        @(negedge clk);
        check("mid_resume_r0", R0_data, 8'h73);
        check("mid_resume_r1", R1_data, 8'h73);
        repeat (2) step();
        check("mid_q0_empty", q0.size(), 0);
        check("mid_q1_empty", q1.size(), 0);

        // Random tokens with random readies, from a fresh reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        accepted = 0;
        cycles = 0;
        while (accepted < 1000 && cycles < 20000) begin
            @(negedge clk);
            acc = L_valid && L_ready;
            step();
            cycles++;
            if (acc) accepted++;
            if (!L_valid || acc) begin
                if (accepted < 1000 && $urandom_range(3) != 0) begin
                    L_valid = 1'b1;
                    L_data = 8'($urandom);
                end else begin
                    L_valid = 1'b0;
                end
            end
            R0_ready = ($urandom_range(9) < 7);
            R1_ready = ($urandom_range(9) < 7);
        end
        check("rand_accepted", accepted, 1000);
        L_valid = 1'b0; R0_ready = 1'b1; R1_ready = 1'b1;
        repeat (3) step();
        check("rand_q0_empty", q0.size(), 0);
        check("rand_q1_empty", q1.size(), 0);
`ifdef COPY_CNT_EN
        check("tok_cnt", tok_cnt, 1000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
